// File: rtl/core_pipe_wb_fsm.sv
// ----------------------------------------------------------------------------
// core_pipe_wb_fsm
//   Writeback stage of the croyde core pipeline. Holds one instruction handed
//   over by the execute stage and completes it: GPR writeback, one-shot CSR
//   access, waiting on the load response, and trap / MRET redirects through a
//   cf_valid / cf_ack handshake. Retires at most one instruction per cycle and
//   accepts the next instruction in the same cycle it retires the current one.
//
// Ports
//   g_clk, g_resetn          clock, asynchronous active-low reset
//   s3_*                     instruction offered by execute (valid/ready)
//   dmem_rsp_*, dmem_rdata   load response
//   csr_*                    CSR access strobes, address, data, read-back
//   mtvec, mepc              redirect targets for trap / MRET
//   rd_wen/addr/wdata        GPR write port
//   cf_valid/target/ack      control-flow redirect handshake
//   trap_cpu/cause/mtval/pc  trap report, pulsed on the redirect ack cycle
//   exec_mret, instr_ret     MRET and retire pulses
// ----------------------------------------------------------------------------
module core_pipe_wb_fsm #(
   parameter int unsigned XLEN           = 64,
   parameter int unsigned CAUSE_W        = 6,
   parameter int unsigned LD_FAULT_CAUSE = 5
) (
   input  logic               g_clk,
   input  logic               g_resetn,
   input  logic               s3_valid,
   output logic               s3_ready,
   input  logic [XLEN-1:0]    s3_pc,
   input  logic [31:0]        s3_instr,
   input  logic [XLEN-1:0]    s3_wdata,
   input  logic [4:0]         s3_rd,
   input  logic               s3_ld,
   input  logic [1:0]         s3_ld_size,
   input  logic               s3_ld_sext,
   input  logic [3:0]         s3_csr_op,
   input  logic [11:0]        s3_csr_addr,
   input  logic               s3_mret,
   input  logic               s3_trap,
   input  logic [CAUSE_W-1:0] s3_trap_cause,
   input  logic               dmem_rsp_valid,
   input  logic               dmem_rsp_err,
   input  logic [XLEN-1:0]    dmem_rdata,
   output logic               csr_en,
   output logic               csr_wr,
   output logic               csr_wr_set,
   output logic               csr_wr_clr,
   output logic [11:0]        csr_addr,
   output logic [XLEN-1:0]    csr_wdata,
   input  logic [XLEN-1:0]    csr_rdata,
   input  logic               csr_error,
   input  logic [XLEN-1:0]    mtvec,
   input  logic [XLEN-1:0]    mepc,
   output logic               rd_wen,
   output logic [4:0]         rd_addr,
   output logic [XLEN-1:0]    rd_wdata,
   output logic               cf_valid,
   output logic [XLEN-1:0]    cf_target,
   input  logic               cf_ack,
   output logic               trap_cpu,
   output logic [CAUSE_W-1:0] trap_cause,
   output logic [XLEN-1:0]    trap_mtval,
   output logic [XLEN-1:0]    trap_pc,
   output logic               exec_mret,
   output logic               instr_ret
);

   localparam int unsigned OFF_W = $clog2(XLEN / 8);

   typedef enum logic [1:0] {
      S_IDLE,
      S_EXEC,
      S_WAIT_LD,
      S_CF
   } state_e;

   typedef struct packed {
      logic [XLEN-1:0]    pc;
      logic [31:0]        instr;
      logic [XLEN-1:0]    wdata;
      logic [4:0]         rd;
      logic               ld;
      logic [1:0]         ld_size;
      logic               ld_sext;
      logic [3:0]         csr_op;
      logic [11:0]        csr_addr;
      logic               mret;
      logic               trap;
      logic [CAUSE_W-1:0] trap_cause;
   } ir_t;

   state_e             state_q, state_d;
   ir_t                ir_q, ir_d;
   logic               cf_trap_q, cf_trap_d;
   logic [XLEN-1:0]    cf_target_q, cf_target_d;
   logic [CAUSE_W-1:0] cf_cause_q, cf_cause_d;
   logic [XLEN-1:0]    cf_mtval_q, cf_mtval_d;

   logic               go_cf;
   logic               done;
   logic               ld_resp;
   logic               wb_en;
   logic [XLEN-1:0]    wb_data;

   // Load data alignment: the address offset inside the XLEN word selects the
   // lowest byte, then the field is masked to the access size and extended.
   logic [OFF_W+2:0]   ld_shamt;
   logic [XLEN-1:0]    ld_shifted;
   logic [XLEN-1:0]    ld_fill;
   logic [XLEN-1:0]    ld_fmt;
   logic               ld_sign;
   int unsigned        ld_bits;

   always_comb begin
      ld_shamt   = {ir_q.wdata[OFF_W-1:0], 3'b000};
      ld_shifted = dmem_rdata >> ld_shamt;
      case (ir_q.ld_size)
         2'd0:    begin ld_bits = 8;    ld_sign = ld_shifted[7];      end
         2'd1:    begin ld_bits = 16;   ld_sign = ld_shifted[15];     end
         2'd2:    begin ld_bits = 32;   ld_sign = ld_shifted[31];     end
         default: begin ld_bits = XLEN; ld_sign = ld_shifted[XLEN-1]; end
      endcase
      // Shifting by XLEN yields an empty fill mask, so D (and D on a 32-bit
      // core, which degenerates to W) passes the word through untouched.
      ld_fill = {XLEN{1'b1}} << ld_bits;
      ld_fmt  = (ld_shifted & ~ld_fill) | (ld_fill & {XLEN{ir_q.ld_sext & ld_sign}});
   end

   always_ff @(posedge g_clk or negedge g_resetn) begin
      if (!g_resetn) begin
         state_q     <= S_IDLE;
         ir_q        <= '0;
         cf_trap_q   <= 1'b0;
         cf_target_q <= '0;
         cf_cause_q  <= '0;
         cf_mtval_q  <= '0;
      end else begin
         state_q     <= state_d;
         ir_q        <= ir_d;
         cf_trap_q   <= cf_trap_d;
         cf_target_q <= cf_target_d;
         cf_cause_q  <= cf_cause_d;
         cf_mtval_q  <= cf_mtval_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      ir_d        = ir_q;
      cf_trap_d   = cf_trap_q;
      cf_target_d = cf_target_q;
      cf_cause_d  = cf_cause_q;
      cf_mtval_d  = cf_mtval_q;
      go_cf       = 1'b0;
      done        = 1'b0;
      ld_resp     = 1'b0;
      wb_en       = 1'b0;
      wb_data     = '0;

      csr_en      = 1'b0;
      csr_wr      = 1'b0;
      csr_wr_set  = 1'b0;
      csr_wr_clr  = 1'b0;
      csr_addr    = '0;
      csr_wdata   = '0;
      cf_valid    = 1'b0;
      cf_target   = '0;
      trap_cpu    = 1'b0;
      trap_cause  = '0;
      trap_mtval  = '0;
      trap_pc     = '0;
      exec_mret   = 1'b0;
      instr_ret   = 1'b0;

      case (state_q)
         S_EXEC: begin
            if (ir_q.trap) begin
               go_cf      = 1'b1;
               cf_trap_d  = 1'b1;
               cf_cause_d = ir_q.trap_cause;
               cf_mtval_d = '0;
            end else if (ir_q.mret) begin
               go_cf      = 1'b1;
               cf_trap_d  = 1'b0;
            end else if (ir_q.csr_op != 4'd0) begin
               csr_en     = 1'b1;
               csr_wr     = ir_q.csr_op[1];
               csr_wr_set = ir_q.csr_op[2];
               csr_wr_clr = ir_q.csr_op[3];
               csr_addr   = ir_q.csr_addr;
               csr_wdata  = ir_q.wdata;
               if (csr_error) begin
                  go_cf      = 1'b1;
                  cf_trap_d  = 1'b1;
                  cf_cause_d = CAUSE_W'(2);
                  cf_mtval_d = XLEN'(ir_q.instr);
               end else begin
                  done      = 1'b1;
                  instr_ret = 1'b1;
                  wb_en     = ir_q.csr_op[0];
                  wb_data   = csr_rdata;
               end
            end else if (ir_q.ld) begin
               if (dmem_rsp_valid) ld_resp = 1'b1;
               else                state_d = S_WAIT_LD;
            end else begin
               done      = 1'b1;
               instr_ret = 1'b1;
               wb_en     = 1'b1;
               wb_data   = ir_q.wdata;
            end
         end
         S_WAIT_LD: begin
            if (dmem_rsp_valid) ld_resp = 1'b1;
         end
         S_CF: begin
            cf_valid  = 1'b1;
            cf_target = cf_target_q;
            if (cf_ack) begin
               done = 1'b1;
               if (cf_trap_q) begin
                  trap_cpu   = 1'b1;
                  trap_cause = cf_cause_q;
                  trap_mtval = cf_mtval_q;
                  trap_pc    = ir_q.pc;
               end else begin
                  exec_mret = 1'b1;
                  instr_ret = 1'b1;
               end
            end
         end
         default: ;
      endcase

      // A load completes identically whether the response met it in EXEC or
      // after waiting in WAIT_LD.
      if (ld_resp) begin
         if (dmem_rsp_err) begin
            go_cf      = 1'b1;
            cf_trap_d  = 1'b1;
            cf_cause_d = CAUSE_W'(LD_FAULT_CAUSE);
            cf_mtval_d = ir_q.wdata;
         end else begin
            done      = 1'b1;
            instr_ret = 1'b1;
            wb_en     = 1'b1;
            wb_data   = ld_fmt;
         end
      end

      // Target is captured on entry so it cannot move while awaiting ack.
      if (go_cf) begin
         state_d     = S_CF;
         cf_target_d = cf_trap_d ? mtvec : mepc;
      end

      rd_wen   = wb_en && (ir_q.rd != 5'd0);
      rd_addr  = rd_wen ? ir_q.rd : 5'd0;
      rd_wdata = rd_wen ? wb_data : '0;

      s3_ready = (state_q == S_IDLE) || done;

      if (done) state_d = S_IDLE;

      if (s3_valid && s3_ready) begin
         state_d          = S_EXEC;
         ir_d.pc          = s3_pc;
         ir_d.instr       = s3_instr;
         ir_d.wdata       = s3_wdata;
         ir_d.rd          = s3_rd;
         ir_d.ld          = s3_ld;
         ir_d.ld_size     = s3_ld_size;
         ir_d.ld_sext     = s3_ld_sext;
         ir_d.csr_op      = s3_csr_op;
         ir_d.csr_addr    = s3_csr_addr;
         ir_d.mret        = s3_mret;
         ir_d.trap        = s3_trap;
         ir_d.trap_cause  = s3_trap_cause;
      end
   end

endmodule

// File: tb/tb_core_pipe_wb_fsm.sv
// ----------------------------------------------------------------------------
// tb_core_pipe_wb_fsm
//   Self-checking bench for core_pipe_wb_fsm (XLEN=64). Each scenario task
//   drives the stage and pushes the writeback / trap / MRET event it expects
//   onto a queue; a negedge monitor pops and compares whenever the stage
//   produces one of those events.
// ----------------------------------------------------------------------------
module tb_core_pipe_wb_fsm;

   localparam int unsigned XLEN = 64;
   localparam int unsigned CW   = 6;

   localparam logic [1:0] K_WB   = 2'd0;
   localparam logic [1:0] K_TRAP = 2'd1;
   localparam logic [1:0] K_MRET = 2'd2;

   typedef struct packed {
      logic [1:0]      kind;
      logic [4:0]      rd;
      logic [63:0]     data;   // rd_wdata for K_WB, mtval for K_TRAP
      logic [CW-1:0]   cause;
      logic [63:0]     pc;
      logic            chk_tval;
   } exp_t;

   exp_t sbq[$];
   int   tests = 0;
   int   fails = 0;

   logic            g_clk = 1'b0;
   logic            g_resetn = 1'b0;
   logic            s3_valid = 1'b0;
   logic            s3_ready;
   logic [XLEN-1:0] s3_pc = '0;
   logic [31:0]     s3_instr = '0;
   logic [XLEN-1:0] s3_wdata = '0;
   logic [4:0]      s3_rd = '0;
   logic            s3_ld = 1'b0;
   logic [1:0]      s3_ld_size = '0;
   logic            s3_ld_sext = 1'b0;
   logic [3:0]      s3_csr_op = '0;
   logic [11:0]     s3_csr_addr = '0;
   logic            s3_mret = 1'b0;
   logic            s3_trap = 1'b0;
   logic [CW-1:0]   s3_trap_cause = '0;
   logic            dmem_rsp_valid = 1'b0;
   logic            dmem_rsp_err = 1'b0;
   logic [XLEN-1:0] dmem_rdata = '0;
   logic            csr_en, csr_wr, csr_wr_set, csr_wr_clr;
   logic [11:0]     csr_addr;
   logic [XLEN-1:0] csr_wdata;
   logic [XLEN-1:0] csr_rdata = '0;
   logic            csr_error = 1'b0;
   logic [XLEN-1:0] mtvec = 64'h0000_0000_8000_0000;
   logic [XLEN-1:0] mepc = '0;
   logic            rd_wen;
   logic [4:0]      rd_addr;
   logic [XLEN-1:0] rd_wdata;
   logic            cf_valid;
   logic [XLEN-1:0] cf_target;
   logic            cf_ack = 1'b0;
   logic            trap_cpu;
   logic [CW-1:0]   trap_cause;
   logic [XLEN-1:0] trap_mtval;
   logic [XLEN-1:0] trap_pc;
   logic            exec_mret;
   logic            instr_ret;

   core_pipe_wb_fsm #(.XLEN(XLEN), .CAUSE_W(CW), .LD_FAULT_CAUSE(5)) dut (
      .g_clk(g_clk), .g_resetn(g_resetn),
      .s3_valid(s3_valid), .s3_ready(s3_ready), .s3_pc(s3_pc), .s3_instr(s3_instr),
      .s3_wdata(s3_wdata), .s3_rd(s3_rd), .s3_ld(s3_ld), .s3_ld_size(s3_ld_size),
      .s3_ld_sext(s3_ld_sext), .s3_csr_op(s3_csr_op), .s3_csr_addr(s3_csr_addr),
      .s3_mret(s3_mret), .s3_trap(s3_trap), .s3_trap_cause(s3_trap_cause),
      .dmem_rsp_valid(dmem_rsp_valid), .dmem_rsp_err(dmem_rsp_err), .dmem_rdata(dmem_rdata),
      .csr_en(csr_en), .csr_wr(csr_wr), .csr_wr_set(csr_wr_set), .csr_wr_clr(csr_wr_clr),
      .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_rdata(csr_rdata), .csr_error(csr_error),
      .mtvec(mtvec), .mepc(mepc),
      .rd_wen(rd_wen), .rd_addr(rd_addr), .rd_wdata(rd_wdata),
      .cf_valid(cf_valid), .cf_target(cf_target), .cf_ack(cf_ack),
      .trap_cpu(trap_cpu), .trap_cause(trap_cause), .trap_mtval(trap_mtval), .trap_pc(trap_pc),
      .exec_mret(exec_mret), .instr_ret(instr_ret)
   );

   always #5 g_clk = ~g_clk;

   // Scoreboard monitor
   always @(negedge g_clk) begin
      exp_t e;
      if (g_resetn && (rd_wen || trap_cpu || exec_mret)) begin
         tests++;
         if (sbq.size() == 0) begin
            fails++;
            $display("FAIL sb_unexpected: rd_wen=%0b trap_cpu=%0b exec_mret=%0b rd_wdata=%h, required no event",
                     rd_wen, trap_cpu, exec_mret, rd_wdata);
         end else begin
            e = sbq.pop_front();
            case (e.kind)
               K_WB: if (rd_wen !== 1'b1 || trap_cpu !== 1'b0 || exec_mret !== 1'b0 ||
                         rd_addr !== e.rd || rd_wdata !== e.data || instr_ret !== 1'b1) begin
                  fails++;
                  $display("FAIL sb_wb: wen=%0b rd=%0d data=%h ret=%0b, required wen=1 rd=%0d data=%h ret=1",
                           rd_wen, rd_addr, rd_wdata, instr_ret, e.rd, e.data);
               end
               K_TRAP: if (trap_cpu !== 1'b1 || rd_wen !== 1'b0 || exec_mret !== 1'b0 ||
                           trap_cause !== e.cause || trap_pc !== e.pc || instr_ret !== 1'b0 ||
                           (e.chk_tval && trap_mtval !== e.data)) begin
                  fails++;
                  $display("FAIL sb_trap: trap=%0b cause=%0d pc=%h mtval=%h ret=%0b, required trap=1 cause=%0d pc=%h mtval=%h ret=0",
                           trap_cpu, trap_cause, trap_pc, trap_mtval, instr_ret, e.cause, e.pc, e.data);
               end
               default: if (exec_mret !== 1'b1 || instr_ret !== 1'b1 || rd_wen !== 1'b0 || trap_cpu !== 1'b0) begin
                  fails++;
                  $display("FAIL sb_mret: mret=%0b ret=%0b wen=%0b trap=%0b, required mret=1 ret=1 wen=0 trap=0",
                           exec_mret, instr_ret, rd_wen, trap_cpu);
               end
            endcase
         end
      end
   end

   task automatic cyc();
      @(posedge g_clk);
      #1;
   endtask

   task automatic set_s3(input logic [63:0] pc, input logic [31:0] instr, input logic [63:0] wdata,
                         input logic [4:0] rd, input logic ld, input logic [1:0] sz, input logic sext,
                         input logic [3:0] cop, input logic [11:0] caddr, input logic mret,
                         input logic trap, input logic [CW-1:0] cause);
      s3_pc = pc; s3_instr = instr; s3_wdata = wdata; s3_rd = rd; s3_ld = ld;
      s3_ld_size = sz; s3_ld_sext = sext; s3_csr_op = cop; s3_csr_addr = caddr;
      s3_mret = mret; s3_trap = trap; s3_trap_cause = cause;
   endtask

   // Offer the staged instruction; returns 1 ns after the accepting edge.
   task automatic offer();
      bit got = 0;
      s3_valid = 1'b1;
      for (int k = 0; k < 20; k++) begin
         @(negedge g_clk);
         if (s3_ready === 1'b1) begin
            got = 1;
            break;
         end
      end
      if (!got) begin
         tests++; fails++;
         $display("FAIL offer_timeout: s3_ready=%0b after 20 cycles, required 1", s3_ready);
      end
      cyc();
      s3_valid = 1'b0;
   endtask

   function automatic logic [63:0] ld_model(input logic [1:0] sz, input logic sext,
                                           input logic [63:0] addr, input logic [63:0] data);
      logic [63:0] sh;
      logic [2:0]  off;
      off = addr[2:0];
      sh  = data >> (8 * off);
      case (sz)
         2'd0:    ld_model = sext ? {{56{sh[7]}},  sh[7:0]}  : {56'd0, sh[7:0]};
         2'd1:    ld_model = sext ? {{48{sh[15]}}, sh[15:0]} : {48'd0, sh[15:0]};
         2'd2:    ld_model = sext ? {{32{sh[31]}}, sh[31:0]} : {32'd0, sh[31:0]};
         default: ld_model = sh;
      endcase
   endfunction

   task automatic test_reset();
      g_resetn = 1'b0;
      repeat (2) @(negedge g_clk);
      tests++;
      if (s3_ready !== 1'b1) begin
         fails++; $display("FAIL reset_ready: s3_ready=%0b, required 1", s3_ready);
      end
      tests++;
      if ({rd_wen, csr_en, cf_valid, trap_cpu, exec_mret, instr_ret} !== 6'b0 ||
          rd_wdata !== '0 || cf_target !== '0 || csr_addr !== '0) begin
         fails++;
         $display("FAIL reset_outputs: wen=%0b csr=%0b cf=%0b trap=%0b mret=%0b ret=%0b, required all 0",
                  rd_wen, csr_en, cf_valid, trap_cpu, exec_mret, instr_ret);
      end
      cyc();
      g_resetn = 1'b1;
      cyc();
   endtask

   task automatic test_alu_b2b();
      for (int i = 0; i < 4; i++) sbq.push_back('{K_WB, 5'd5, 64'h1234 + 64'(i), '0, '0, 1'b0});
      set_s3(64'h1000, 32'h0, 64'h1234, 5'd5, 0, 0, 0, 0, 0, 0, 0, 0);
      s3_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge g_clk);
         tests++;
         if (s3_ready !== 1'b1) begin
            fails++; $display("FAIL b2b_ready[%0d]: s3_ready=%0b, required 1", i, s3_ready);
         end
         if (i > 0) begin
            tests++;
            if (instr_ret !== 1'b1) begin
               fails++; $display("FAIL b2b_ret[%0d]: instr_ret=%0b, required 1", i, instr_ret);
            end
         end
         cyc();
         if (i < 3) s3_wdata = 64'h1234 + 64'(i + 1);
         else       s3_valid = 1'b0;
      end
      @(negedge g_clk);
      tests++;
      if (instr_ret !== 1'b1) begin
         fails++; $display("FAIL b2b_ret_last: instr_ret=%0b, required 1", instr_ret);
      end
      cyc();
      // rd=x0: retires without a GPR write
      set_s3(64'h1010, 32'h0, 64'hDEAD, 5'd0, 0, 0, 0, 0, 0, 0, 0, 0);
      offer();
      @(negedge g_clk);
      tests++;
      if (rd_wen !== 1'b0 || instr_ret !== 1'b1) begin
         fails++; $display("FAIL alu_x0: rd_wen=%0b instr_ret=%0b, required 0 and 1", rd_wen, instr_ret);
      end
      cyc();
   endtask

   task automatic test_load(input logic [1:0] sz, input logic sext, input logic [63:0] addr,
                            input logic [63:0] data, input int delay);
      sbq.push_back('{K_WB, 5'd9, ld_model(sz, sext, addr, data), '0, '0, 1'b0});
      set_s3(64'h2000, 32'h0, addr, 5'd9, 1, sz, sext, 0, 0, 0, 0, 0);
      offer();
      for (int k = 0; k < delay; k++) begin
         @(negedge g_clk);
         tests++;
         if (s3_ready !== 1'b0 || rd_wen !== 1'b0) begin
            fails++;
            $display("FAIL load_wait[%0d]: s3_ready=%0b rd_wen=%0b, required 0 and 0", k, s3_ready, rd_wen);
         end
         cyc();
      end
      dmem_rsp_valid = 1'b1;
      dmem_rdata     = data;
      @(negedge g_clk);
      cyc();
      dmem_rsp_valid = 1'b0;
      dmem_rdata     = '0;
   endtask

   task automatic test_csr(input logic err);
      int n_en = 0;
      bit any_wen = 0;
      if (!err) sbq.push_back('{K_WB, 5'd7, 64'hAA, '0, '0, 1'b0});
      else      sbq.push_back('{K_TRAP, 5'd0, 64'h3400_93F3, CW'(2), 64'h3000, 1'b1});
      set_s3(64'h3000, 32'h3400_93F3, 64'h55, 5'd7, 0, 0, 0, 4'b0011, 12'h340, 0, 0, 0);
      offer();
      csr_rdata = 64'hAA;
      csr_error = err;
      for (int k = 0; k < 4; k++) begin
         @(negedge g_clk);
         if (csr_en === 1'b1) n_en++;
         if (rd_wen === 1'b1) any_wen = 1;
         if (k == 0) begin
            tests++;
            if (csr_en !== 1'b1 || csr_wr !== 1'b1 || csr_wr_set !== 1'b0 || csr_wr_clr !== 1'b0 ||
                csr_addr !== 12'h340 || csr_wdata !== 64'h55) begin
               fails++;
               $display("FAIL csr_strobe: en=%0b wr=%0b set=%0b clr=%0b addr=%h wdata=%h, required 1 1 0 0 340 55",
                        csr_en, csr_wr, csr_wr_set, csr_wr_clr, csr_addr, csr_wdata);
            end
         end
         if (err && k == 1) begin
            tests++;
            if (cf_valid !== 1'b1 || cf_target !== mtvec) begin
               fails++;
               $display("FAIL csr_err_cf: cf_valid=%0b cf_target=%h, required 1 and %h", cf_valid, cf_target, mtvec);
            end
         end
         cyc();
         if (k == 0) begin
            csr_error = 1'b0;
            csr_rdata = '0;
            if (err) cf_ack = 1'b1;
         end
         if (k == 1) cf_ack = 1'b0;
      end
      tests++;
      if (n_en != 1) begin
         fails++; $display("FAIL csr_en_count: csr_en cycles=%0d, required 1", n_en);
      end
      if (err) begin
         tests++;
         if (any_wen) begin
            fails++; $display("FAIL csr_err_wen: rd_wen seen=1, required 0");
         end
      end
   endtask

   task automatic test_ld_err();
      logic [63:0] old_mtvec;
      old_mtvec = mtvec;
      sbq.push_back('{K_TRAP, 5'd0, 64'h8000_0010, CW'(5), 64'h4000, 1'b1});
      set_s3(64'h4000, 32'h0, 64'h8000_0010, 5'd9, 1, 2'd2, 0, 0, 0, 0, 0, 0);
      offer();
      dmem_rsp_valid = 1'b1;
      dmem_rsp_err   = 1'b1;
      @(negedge g_clk);
      cyc();
      dmem_rsp_valid = 1'b0;
      dmem_rsp_err   = 1'b0;
      for (int k = 0; k < 3; k++) begin
         if (k == 1) mtvec = 64'h9999_0000;
         if (k == 2) cf_ack = 1'b1;
         @(negedge g_clk);
         tests++;
         if (cf_valid !== 1'b1 || cf_target !== old_mtvec) begin
            fails++;
            $display("FAIL ld_err_cf[%0d]: cf_valid=%0b cf_target=%h, required 1 and %h", k, cf_valid, cf_target, old_mtvec);
         end
         if (k < 2) begin
            tests++;
            if (trap_cpu !== 1'b0 || instr_ret !== 1'b0) begin
               fails++; $display("FAIL ld_err_early[%0d]: trap_cpu=%0b instr_ret=%0b, required 0", k, trap_cpu, instr_ret);
            end
         end
         cyc();
      end
      cf_ack = 1'b0;
      mtvec  = old_mtvec;
      @(negedge g_clk);
      tests++;
      if (cf_valid !== 1'b0) begin
         fails++; $display("FAIL ld_err_cf_drop: cf_valid=%0b, required 0", cf_valid);
      end
      cyc();
   endtask

   task automatic test_mret();
      mepc = 64'h8000_0100;
      sbq.push_back('{K_MRET, 5'd0, '0, '0, 64'h5000, 1'b0});
      set_s3(64'h5000, 32'h3020_0073, 0, 5'd0, 0, 0, 0, 0, 0, 1, 0, 0);
      offer();
      @(negedge g_clk);
      tests++;
      if (cf_valid !== 1'b0 || exec_mret !== 1'b0) begin
         fails++; $display("FAIL mret_exec: cf_valid=%0b exec_mret=%0b, required 0 and 0", cf_valid, exec_mret);
      end
      cyc();
      cf_ack = 1'b1;
      @(negedge g_clk);
      tests++;
      if (cf_valid !== 1'b1 || cf_target !== 64'h8000_0100) begin
         fails++; $display("FAIL mret_cf: cf_valid=%0b cf_target=%h, required 1 and 80000100", cf_valid, cf_target);
      end
      cyc();
      cf_ack = 1'b0;
   endtask

   task automatic test_upstream_trap();
      sbq.push_back('{K_TRAP, 5'd0, '0, CW'(3), 64'h6000, 1'b0});
      set_s3(64'h6000, 32'h0, 64'h99, 5'd5, 0, 0, 0, 4'b0011, 12'h340, 0, 1, CW'(3));
      offer();
      @(negedge g_clk);
      tests++;
      if (csr_en !== 1'b0 || rd_wen !== 1'b0 || cf_valid !== 1'b0) begin
         fails++; $display("FAIL utrap_exec: csr_en=%0b rd_wen=%0b cf_valid=%0b, required 0 0 0", csr_en, rd_wen, cf_valid);
      end
      cyc();
      cf_ack = 1'b1;
      @(negedge g_clk);
      tests++;
      if (cf_valid !== 1'b1 || cf_target !== mtvec) begin
         fails++; $display("FAIL utrap_cf: cf_valid=%0b cf_target=%h, required 1 and %h", cf_valid, cf_target, mtvec);
      end
      cyc();
      cf_ack = 1'b0;
   endtask

   task automatic test_reset_mid();
      set_s3(64'h7000, 32'h0, 64'h10, 5'd9, 1, 2'd3, 0, 0, 0, 0, 0, 0);
      offer();
      cyc();
      cyc();
      #2;
      g_resetn = 1'b0;
      #1;
      tests++;
      if (s3_ready !== 1'b1 || rd_wen !== 1'b0 || cf_valid !== 1'b0 || instr_ret !== 1'b0) begin
         fails++;
         $display("FAIL reset_mid: s3_ready=%0b rd_wen=%0b cf_valid=%0b instr_ret=%0b, required 1 0 0 0",
                  s3_ready, rd_wen, cf_valid, instr_ret);
      end
      cyc();
      g_resetn = 1'b1;
      dmem_rsp_valid = 1'b1;
      dmem_rdata     = 64'h1111_2222_3333_4444;
      for (int k = 0; k < 2; k++) begin
         @(negedge g_clk);
         tests++;
         if (rd_wen !== 1'b0 || instr_ret !== 1'b0) begin
            fails++; $display("FAIL reset_late_rsp[%0d]: rd_wen=%0b instr_ret=%0b, required 0 and 0", k, rd_wen, instr_ret);
         end
         cyc();
      end
      dmem_rsp_valid = 1'b0;
      dmem_rdata     = '0;
   endtask

   initial begin
      test_reset();
      test_alu_b2b();
      test_load(2'd0, 1'b1, 64'h0000_0000_0000_0003, 64'h0000_0000_8000_0000, 3);
      test_load(2'd0, 1'b0, 64'h0000_0000_0000_0003, 64'h0000_0000_8000_0000, 3);
      test_load(2'd1, 1'b1, 64'h0000_0000_0000_0006, 64'h8001_0000_0000_0000, 0);
      test_load(2'd2, 1'b0, 64'h0000_0000_0000_0004, 64'hDEAD_BEEF_1234_5678, 1);
      test_load(2'd2, 1'b1, 64'h0000_0000_0000_0004, 64'hDEAD_BEEF_1234_5678, 0);
      test_load(2'd3, 1'b0, 64'h0000_0000_0000_0000, 64'h0123_4567_89AB_CDEF, 2);
      test_csr(1'b0);
      test_csr(1'b1);
      test_ld_err();
      test_mret();
      test_upstream_trap();
      test_reset_mid();
      repeat (2) @(negedge g_clk);
      tests++;
      if (sbq.size() != 0) begin
         fails++; $display("FAIL sb_drain: %0d expected events never seen, required 0", sbq.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
